// File: rtl/dmem_axi_bridge.sv
// Converts the core's sram-like data port into AXI4 read/write channels.
// Only one transaction is outstanding at a time.
//
// state  | meaning
// IDLE   | ready to accept a core request (addr_ok high)
// RD_AR  | read address presented, waiting for arready
// RD_R   | waiting for read data beat
// WR_AWW | write address and data presented, each drops on its own handshake
// WR_B   | waiting for write response
module dmem_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req,
    input  logic                    wr,
    input  logic [1:0]              size,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arsize,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata_axi,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awsize,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata_axi,
    output logic [DATA_WIDTH/8-1:0] wstrb_axi,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4
    } state_t;

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [1:0]                size_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      aw_done, w_done;
    logic                      data_ok_q;
    logic                      accept;
    logic                      rd_fin, wr_fin;

    // addr_ok is gated by reset so nothing reads as accepted while held in reset
    assign addr_ok = resetn && (state == IDLE);
    assign accept  = req && addr_ok;
    assign rd_fin  = (state == RD_R) && rvalid;
    assign wr_fin  = (state == WR_B) && bvalid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = wr ? WR_AWW : RD_AR;
            RD_AR:  if (arready) state_nxt = RD_R;
            RD_R:   if (rvalid) state_nxt = IDLE;
            WR_AWW: if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_B;
            WR_B:   if (bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_ok_q <= rd_fin || wr_fin;
            if (accept) begin
                addr_q  <= addr;
                size_q  <= size;
                wstrb_q <= wstrb;
                wdata_q <= wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_AWW) begin
                if (awready) aw_done <= 1'b1;
                if (wready)  w_done  <= 1'b1;
            end
            if (rd_fin) rdata_q <= rdata_axi;
        end
    end

    assign data_ok   = data_ok_q;
    assign rdata     = rdata_q;
    assign araddr    = addr_q;
    assign arsize    = {1'b0, size_q};
    assign arvalid   = (state == RD_AR);
    assign rready    = (state == RD_R);
    assign awaddr    = addr_q;
    assign awsize    = {1'b0, size_q};
    assign awvalid   = (state == WR_AWW) && !aw_done;
    assign wdata_axi = wdata_q;
    assign wstrb_axi = wstrb_q;
    assign wvalid    = (state == WR_AWW) && !w_done;
    assign bready    = (state == WR_B);

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: the bench plays both the core and the AXI slave.
module tb_dmem_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, araddr, rdata_axi, awaddr, wdata_axi;
    logic [3:0]  wstrb, wstrb_axi;
    logic        addr_ok, data_ok, arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [2:0]  arsize, awsize;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int dok_cnt = 0;

    dmem_axi_bridge dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (data_ok === 1'b1) dok_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wstrb = '0; wdata = '0;
        arready = 1'b0; rvalid = 1'b0; rdata_axi = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // reset state
        tick(); tick();
        check("rst_addr_ok", 32'(addr_ok), 32'd0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
        check("rst_readys", {29'd0, rready, bready, 1'b0}, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_addr_ok", 32'(addr_ok), 32'd1);

        // load word, zero-wait slave
        req = 1'b1; wr = 1'b0; addr = 32'h1c000010; size = 2'd2;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'hdeadbeef;
        check("ld_accept", 32'(addr_ok), 32'd1);
        tick(); req = 1'b0;
        check("ld_arvalid_t1", 32'(arvalid), 32'd1);
        check("ld_araddr", araddr, 32'h1c000010);
        check("ld_arsize", 32'(arsize), 32'd2);
        check("ld_addr_ok_busy", 32'(addr_ok), 32'd0);
        check("ld_data_ok_t1", 32'(data_ok), 32'd0);
        tick();
        check("ld_rready_t2", 32'(rready), 32'd1);
        check("ld_arvalid_t2", 32'(arvalid), 32'd0);
        check("ld_data_ok_t2", 32'(data_ok), 32'd0);
        tick();
        check("ld_data_ok_t3", 32'(data_ok), 32'd1);
        check("ld_rdata_t3", rdata, 32'hdeadbeef);
        check("ld_idle_t3", 32'(addr_ok), 32'd1);
        arready = 1'b0; rvalid = 1'b0; rdata_axi = 32'h11111111;
        tick();
        check("ld_data_ok_t4", 32'(data_ok), 32'd0);
        check("ld_rdata_hold", rdata, 32'hdeadbeef);

        // store byte, awready delayed 3 cycles
        req = 1'b1; wr = 1'b1; addr = 32'h1c000003; size = 2'd0; wstrb = 4'b1000; wdata = 32'h55000000;
        wready = 1'b1; awready = 1'b0;
        tick(); req = 1'b0;
        check("st_awvalid_t1", 32'(awvalid), 32'd1);
        check("st_wvalid_t1", 32'(wvalid), 32'd1);
        check("st_awaddr", awaddr, 32'h1c000003);
        check("st_awsize", 32'(awsize), 32'd0);
        check("st_wstrb", 32'(wstrb_axi), 32'h8);
        check("st_wdata", wdata_axi, 32'h55000000);
        tick();
        check("st_wvalid_done", 32'(wvalid), 32'd0);
        check("st_awvalid_t2", 32'(awvalid), 32'd1);
        tick();
        check("st_awvalid_t3", 32'(awvalid), 32'd1);
        check("st_awaddr_stable", awaddr, 32'h1c000003);
        tick(); awready = 1'b1;
        check("st_awvalid_t4", 32'(awvalid), 32'd1);
        check("st_bready_t4", 32'(bready), 32'd0);
        tick(); awready = 1'b0;
        check("st_awvalid_t5", 32'(awvalid), 32'd0);
        check("st_bready_t5", 32'(bready), 32'd1);
        check("st_data_ok_t5", 32'(data_ok), 32'd0);
        tick(); bvalid = 1'b1;
        check("st_bready_t6", 32'(bready), 32'd1);
        check("st_data_ok_t6", 32'(data_ok), 32'd0);
        tick(); bvalid = 1'b0; wready = 1'b0;
        check("st_data_ok_t7", 32'(data_ok), 32'd1);
        check("st_bready_t7", 32'(bready), 32'd0);
        check("st_rdata_unchanged", rdata, 32'hdeadbeef);
        tick();
        check("st_data_ok_t8", 32'(data_ok), 32'd0);

        // stalled AR with a second request held on the core side
        req = 1'b1; wr = 1'b0; addr = 32'h00000044; size = 2'd1;
        tick();
        req = 1'b1; wr = 1'b1; addr = 32'h00000099; size = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check("stall_arvalid", 32'(arvalid), 32'd1);
            check("stall_araddr", araddr, 32'h00000044);
            check("stall_arsize", 32'(arsize), 32'd1);
            check("stall_addr_ok", 32'(addr_ok), 32'd0);
            check("stall_no_aw", 32'(awvalid), 32'd0);
            tick();
        end
        req = 1'b0; arready = 1'b1;
        check("stall_arvalid_end", 32'(arvalid), 32'd1);
        tick(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h12345678;
        check("stall_rready", 32'(rready), 32'd1);
        check("stall_araddr_kept", araddr, 32'h00000044);
        tick(); rvalid = 1'b0;
        check("stall_data_ok", 32'(data_ok), 32'd1);
        check("stall_rdata", rdata, 32'h12345678);
        tick();
        check("stall_data_ok_once", 32'(data_ok), 32'd0);
        check("stall_idle", 32'(addr_ok), 32'd1);

        // back-to-back: store then load held on req
        req = 1'b1; wr = 1'b1; addr = 32'h00000100; size = 2'd2; wstrb = 4'hf; wdata = 32'ha5a5a5a5;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        check("b2b_st_accept", 32'(addr_ok), 32'd1);
        tick();
        wr = 1'b0; addr = 32'h00000200;
        check("b2b_aw_w", {30'd0, awvalid, wvalid}, 32'd3);
        check("b2b_busy", 32'(addr_ok), 32'd0);
        tick();
        check("b2b_bready", 32'(bready), 32'd1);
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'hcafef00d;
        check("b2b_st_data_ok", 32'(data_ok), 32'd1);
        check("b2b_ld_accept", 32'(addr_ok), 32'd1);
        tick(); req = 1'b0;
        check("b2b_ld_arvalid", 32'(arvalid), 32'd1);
        check("b2b_ld_araddr", araddr, 32'h00000200);
        check("b2b_gap", 32'(data_ok), 32'd0);
        tick();
        check("b2b_ld_rready", 32'(rready), 32'd1);
        tick();
        arready = 1'b0; rvalid = 1'b0;
        check("b2b_ld_data_ok", 32'(data_ok), 32'd1);
        check("b2b_ld_rdata", rdata, 32'hcafef00d);
        tick();
        check("b2b_ld_done", 32'(data_ok), 32'd0);
        check("pulse_count", 32'(dok_cnt), 32'd5);

        // async reset while in RD_R
        req = 1'b1; wr = 1'b0; addr = 32'h00000300; size = 2'd2; arready = 1'b1;
        tick(); req = 1'b0;
        tick(); arready = 1'b0;
        check("ar_rst_pre_rready", 32'(rready), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("ar_rst_rready", 32'(rready), 32'd0);
        check("ar_rst_arvalid", 32'(arvalid), 32'd0);
        check("ar_rst_data_ok", 32'(data_ok), 32'd0);
        check("ar_rst_rdata", rdata, 32'd0);
        check("ar_rst_araddr", araddr, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("ar_rel_addr_ok", 32'(addr_ok), 32'd1);
        req = 1'b1; wr = 1'b0; addr = 32'h00000304; size = 2'd2;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'h0badf00d;
        tick(); req = 1'b0;
        check("ar_fresh_araddr", araddr, 32'h00000304);
        tick();
        check("ar_fresh_no_early", 32'(data_ok), 32'd0);
        tick();
        arready = 1'b0; rvalid = 1'b0;
        check("ar_fresh_data_ok", 32'(data_ok), 32'd1);
        check("ar_fresh_rdata", rdata, 32'h0badf00d);
        tick();
        check("ar_fresh_single", 32'(data_ok), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
